xpb_lut_bank: RTL and testbench

Runtime-loadable, multi-channel successor to the fixed per-segment XPB reduction tables used by the modular squaring datapath. The block holds NUM_LUTS tables of 2^IDX_W precomputed DATA_W-bit constants (multiples of 2^k mod N), loaded from a narrow word stream, so a new modulus needs no re-synthesis. All NUM_LUTS channels are looked up in parallel through a registered two-stage read pipeline, and the outputs feed the reduction adder tree.

---
 rtl/xpb_lut_bank_if.sv | 29 ++
 rtl/xpb_lut_bank.sv | 149 ++++++++++++++
 tb/tb_xpb_lut_bank.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/xpb_lut_bank_if.sv
// Load-stream, lookup-request and result signals of the XPB reduction table bank.
// The master drives loads and lookups; the slave is the table bank itself.
interface xpb_lut_bank_if #(
  parameter int NUM_LUTS = 4,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 1024,
  parameter int WORD_W   = 64
);
  logic                         cfg_start;
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [WORD_W-1:0]            cfg_data;
  logic                         table_ready;
  logic                         lookup_valid;
  logic                         lookup_ready;
  logic [NUM_LUTS*IDX_W-1:0]    lookup_idx;
  logic                         out_valid;
  logic [NUM_LUTS*DATA_W-1:0]   out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, lookup_valid, lookup_idx,
    input  cfg_ready, table_ready, lookup_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, lookup_valid, lookup_idx,
    output cfg_ready, table_ready, lookup_ready, out_valid, out_data
  );
endinterface

// File: rtl/xpb_lut_bank.sv
// Runtime-loadable XPB reduction tables: NUM_LUTS channels loaded from a word stream,
// looked up in parallel through a two-stage registered read pipeline.
//
// state   | meaning
// EMPTY   | after reset; contents unusable, words and lookups ignored
// LOADING | accepting the word stream, entries committed as they complete
// READY   | full load done; lookups accepted
module xpb_lut_bank #(
  parameter int NUM_LUTS = 4,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 1024,
  parameter int WORD_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  xpb_lut_bank_if.slave      bus
);
  localparam int WPE  = DATA_W / WORD_W;
  localparam int NENT = (2 ** IDX_W) - 1;
  localparam int WC_W = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int CH_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WPE - 1);
  localparam logic [IDX_W-1:0] ENT_LAST  = IDX_W'(NENT - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_LUTS - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                     state;
  logic                       cfg_ready_q;
  logic                       table_ready_q;
  logic [WC_W-1:0]            word_cnt;
  logic [IDX_W-1:0]           ent_cnt;
  logic [CH_W-1:0]            ch_cnt;
  logic [DATA_W-1:0]          asm_q;
  logic                       commit_pend;
  logic [CH_W-1:0]            commit_ch;
  logic [IDX_W-1:0]           commit_idx;

  logic [DATA_W-1:0]          mem [NUM_LUTS][1:NENT];

  logic                       s1_valid;
  logic [NUM_LUTS*IDX_W-1:0]  s1_idx;
  logic [NUM_LUTS*DATA_W-1:0] rd_data;
  logic                       out_valid_q;
  logic [NUM_LUTS*DATA_W-1:0] out_data_q;

  logic word_acc;
  logic lookup_acc;

  // cfg_start dominates: a word presented alongside a restart is not taken.
  assign word_acc   = bus.cfg_valid & (state == LOADING) & ~bus.cfg_start;
  assign lookup_acc = bus.lookup_valid & bus.lookup_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      cfg_ready_q   <= 1'b0;
      table_ready_q <= 1'b0;
      word_cnt      <= '0;
      ent_cnt       <= '0;
      ch_cnt        <= '0;
      commit_pend   <= 1'b0;
      commit_ch     <= '0;
      commit_idx    <= '0;
    end else begin
      commit_pend <= 1'b0;
      if (bus.cfg_start) begin
        state         <= LOADING;
        cfg_ready_q   <= 1'b1;
        table_ready_q <= 1'b0;
        word_cnt      <= '0;
        ent_cnt       <= '0;
        ch_cnt        <= '0;
      end else if (word_acc) begin
        if (word_cnt == WORD_LAST) begin
          word_cnt    <= '0;
          commit_pend <= 1'b1;
          commit_ch   <= ch_cnt;
          commit_idx  <= ent_cnt + 1'b1;
          if (ent_cnt == ENT_LAST) begin
            ent_cnt <= '0;
            if (ch_cnt == CH_LAST) begin
              ch_cnt        <= '0;
              state         <= READY;
              cfg_ready_q   <= 1'b0;
              table_ready_q <= 1'b1;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end else begin
            ent_cnt <= ent_cnt + 1'b1;
          end
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  // Words shift in from the top so the first (least-significant) word ends at bit 0.
  generate
    if (WPE == 1) begin : g_asm_single
      always_ff @(posedge clk) begin
        if (word_acc) asm_q <= bus.cfg_data;
      end
    end else begin : g_asm_shift
      always_ff @(posedge clk) begin
        if (word_acc) asm_q <= {bus.cfg_data, asm_q[DATA_W-1:WORD_W]};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (commit_pend) mem[commit_ch][commit_idx] <= asm_q;
  end

  generate
    for (genvar c = 0; c < NUM_LUTS; c++) begin : g_rd
      logic [IDX_W-1:0] idx_c;
      assign idx_c = s1_idx[c*IDX_W +: IDX_W];
      assign rd_data[c*DATA_W +: DATA_W] = (idx_c == '0) ? '0 : mem[c][idx_c];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid    <= lookup_acc;
      if (lookup_acc) s1_idx <= bus.lookup_idx;
      out_valid_q <= s1_valid;
      if (s1_valid) out_data_q <= rd_data;
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.table_ready  = table_ready_q;
  assign bus.lookup_ready = table_ready_q & ~bus.cfg_start;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
endmodule

// File: tb/tb_xpb_lut_bank.sv
// Scoreboard bench for xpb_lut_bank: stimulus pushes expected results with a due cycle,
// a negedge monitor pops and compares every out_valid beat.
module tb_xpb_lut_bank;
  localparam int NUM_LUTS = 2;
  localparam int IDX_W    = 2;
  localparam int DATA_W   = 128;
  localparam int WORD_W   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [255:0] data;
    int           due;
  } exp_t;
  exp_t q[$];

  xpb_lut_bank_if #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W), .DATA_W(DATA_W), .WORD_W(WORD_W)) bus ();

  xpb_lut_bank #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W), .DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entry (c, i) of a load whose word n carries base+n.
  function automatic logic [127:0] ent(int base, int c, int i);
    int n;
    if (i == 0) return '0;
    n = (c * 3 + i - 1) * 2;
    return {64'(base + n + 1), 64'(base + n)};
  endfunction

  function automatic logic [255:0] exp_pair(int base, int i0, int i1);
    return {ent(base, 1, i1), ent(base, 0, i0)};
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with no pending request, cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_latency", 256'(cyc), 256'(e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(int i0, int i1, bit exp_acc, logic [255:0] exp_d);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = {2'(i1), 2'(i0)};
    #1;
    chk("lookup_ready", 256'(bus.lookup_ready), 256'(exp_acc));
    @(posedge clk);
    #1;
    if (exp_acc) q.push_back('{exp_d, cyc + 1});
    bus.lookup_valid = 1'b0;
  endtask

  task automatic start_pulse();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("start_cfg_ready", 256'(bus.cfg_ready), 256'd1);
    chk("start_table_ready", 256'(bus.table_ready), 256'd0);
  endtask

  task automatic stream(int base, int cnt, bit gaps, bit final_chk, bit lk);
    for (int n = 0; n < cnt; n++) begin
      if (gaps) begin
        bus.cfg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.cfg_valid    = 1'b1;
      bus.cfg_data     = 64'(base + n);
      bus.lookup_valid = lk;
      #1;
      chk("load_cfg_ready", 256'(bus.cfg_ready), 256'd1);
      chk("load_table_ready", 256'(bus.table_ready), 256'd0);
      if (lk) chk("load_lookup_ready", 256'(bus.lookup_ready), 256'd0);
      @(posedge clk);
      #1;
    end
    bus.cfg_valid    = 1'b0;
    bus.lookup_valid = 1'b0;
    if (final_chk) begin
      chk("done_table_ready", 256'(bus.table_ready), 256'd1);
      chk("done_cfg_ready", 256'(bus.cfg_ready), 256'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_start    = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_data     = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cfg_ready", 256'(bus.cfg_ready), 256'd0);
    chk("rst_table_ready", 256'(bus.table_ready), 256'd0);
    chk("rst_lookup_ready", 256'(bus.lookup_ready), 256'd0);
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_out_data", bus.out_data, 256'd0);
    rst = 1'b0;
    tick();

    // Lookups while EMPTY are dropped.
    repeat (3) lookup(1, 1, 1'b0, '0);
    repeat (3) tick();

    // Basic load, lookups held during LOADING must be dropped too.
    start_pulse();
    stream(32'h100, 12, 1'b0, 1'b1, 1'b1);
    lookup(1, 0, 1'b1, {128'h0, 64'h101, 64'h100});
    lookup(3, 0, 1'b1, {128'h0, 64'h105, 64'h104});
    lookup(0, 3, 1'b1, {64'h10B, 64'h10A, 128'h0});
    repeat (3) tick();

    // Back-to-back lookups.
    lookup(1, 3, 1'b1, exp_pair(32'h100, 1, 3));
    lookup(2, 2, 1'b1, exp_pair(32'h100, 2, 2));
    lookup(3, 1, 1'b1, exp_pair(32'h100, 3, 1));
    lookup(0, 0, 1'b1, 256'h0);
    repeat (4) tick();

    // In-flight lookup completes with old data; lookup alongside cfg_start is dropped.
    lookup(2, 1, 1'b1, exp_pair(32'h100, 2, 1));
    bus.cfg_start = 1'b1;
    lookup(1, 1, 1'b0, '0);
    bus.cfg_start = 1'b0;
    chk("reload_table_ready", 256'(bus.table_ready), 256'd0);
    chk("reload_cfg_ready", 256'(bus.cfg_ready), 256'd1);
    stream(32'h200, 12, 1'b0, 1'b1, 1'b0);
    lookup(1, 0, 1'b1, {128'h0, 64'h201, 64'h200});
    lookup(2, 3, 1'b1, exp_pair(32'h200, 2, 3));
    repeat (3) tick();

    // Restart after 5 words.
    start_pulse();
    stream(32'h300, 5, 1'b0, 1'b0, 1'b0);
    start_pulse();
    stream(32'h400, 12, 1'b0, 1'b1, 1'b0);
    lookup(1, 3, 1'b1, exp_pair(32'h400, 1, 3));
    lookup(2, 2, 1'b1, exp_pair(32'h400, 2, 2));
    lookup(3, 1, 1'b1, exp_pair(32'h400, 3, 1));
    repeat (3) tick();

    // Reset after 7 words.
    start_pulse();
    stream(32'h500, 7, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cfg_ready", 256'(bus.cfg_ready), 256'd0);
    chk("midrst_table_ready", 256'(bus.table_ready), 256'd0);
    chk("midrst_out_valid", 256'(bus.out_valid), 256'd0);
    for (int n = 0; n < 3; n++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 64'(32'h600 + n);
      tick();
      chk("empty_cfg_ready", 256'(bus.cfg_ready), 256'd0);
      chk("empty_table_ready", 256'(bus.table_ready), 256'd0);
    end
    bus.cfg_valid = 1'b0;
    lookup(1, 1, 1'b0, '0);
    repeat (3) tick();

    // Load with idle gaps reproduces the first table set.
    start_pulse();
    stream(32'h100, 12, 1'b1, 1'b1, 1'b0);
    lookup(1, 1, 1'b1, exp_pair(32'h100, 1, 1));
    lookup(2, 3, 1'b1, exp_pair(32'h100, 2, 3));
    lookup(3, 2, 1'b1, exp_pair(32'h100, 3, 2));
    lookup(3, 0, 1'b1, {128'h0, 64'h105, 64'h104});
    repeat (5) tick();
    chk("hold_out_data", bus.out_data, {128'h0, 64'h105, 64'h104});
    chk("sb_drained", 256'(q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
